// File: rtl/bru_pkg.sv
// Shared types and constants for the branch resolve unit: condition encodings,
// predictor counter type, and the PC step size.
package bru_pkg;

   typedef enum logic [2:0] {
      BEQ  = 3'b000,
      BNE  = 3'b001,
      BLT  = 3'b100,
      BGE  = 3'b101,
      BLTU = 3'b110,
      BGEU = 3'b111
   } br_func3_e;

   typedef logic [1:0] bht_ctr_t;

   localparam bht_ctr_t    BHT_WEAK_NT = 2'b01;
   localparam int unsigned PC_STEP     = 4;

endpackage

// File: rtl/bru_cmp.sv
// Branch condition evaluator; purely combinational, zero latency, no flow control.
// Reserved func3 encodings resolve not-taken and raise illegal.
module bru_cmp
   import bru_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] rdata1,
   input  logic [XLEN-1:0] rdata2,
   input  logic [2:0]      func3,
   output logic            taken,
   output logic            illegal
);

   always_comb begin
      taken   = 1'b0;
      illegal = 1'b0;
      case (func3)
         BEQ:     taken = (rdata1 == rdata2);
         BNE:     taken = (rdata1 != rdata2);
         BLT:     taken = ($signed(rdata1) <  $signed(rdata2));
         BGE:     taken = ($signed(rdata1) >= $signed(rdata2));
         BLTU:    taken = (rdata1 <  rdata2);
         BGEU:    taken = (rdata1 >= rdata2);
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolve stage: 1-cycle registered result, in_ready = !out_valid || out_ready
// (holds output under backpressure). BRU_BHT_EN adds a 2-bit-counter fetch predictor.
module branch_resolve_unit
   import bru_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter int BHT_DEPTH = 64,
   parameter int CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [XLEN-1:0]  in_pc,
   input  logic [XLEN-1:0]  in_imm,
   input  logic [XLEN-1:0]  in_rdata1,
   input  logic [XLEN-1:0]  in_rdata2,
   input  logic [2:0]       in_func3,
   input  logic             in_pred_taken,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_taken,
   output logic [XLEN-1:0]  out_next_pc,
   output logic             out_mispredict,
   output logic             out_illegal,
   output logic [CNT_W-1:0] mispredict_cnt,
   input  logic [XLEN-1:0]  pred_pc,
   output logic             pred_taken
);

   localparam int IDX_W = $clog2(BHT_DEPTH);

   logic            cmp_taken;
   logic            cmp_illegal;
   logic            in_hs;
   logic            out_hs;
   logic [XLEN-1:0] target_pc;
   logic [XLEN-1:0] fall_pc;

   bru_cmp #(.XLEN(XLEN)) u_cmp (
      .rdata1  (in_rdata1),
      .rdata2  (in_rdata2),
      .func3   (in_func3),
      .taken   (cmp_taken),
      .illegal (cmp_illegal)
   );

   assign in_ready  = !out_valid || out_ready;
   assign in_hs     = in_valid && in_ready;
   assign out_hs    = out_valid && out_ready;
   assign target_pc = in_pc + in_imm;
   assign fall_pc   = in_pc + XLEN'(PC_STEP);

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid      <= 1'b0;
         out_taken      <= 1'b0;
         out_next_pc    <= '0;
         out_mispredict <= 1'b0;
         out_illegal    <= 1'b0;
         mispredict_cnt <= '0;
      end else begin
         if (in_hs) begin
            out_valid      <= 1'b1;
            out_taken      <= cmp_taken;
            out_next_pc    <= cmp_taken ? target_pc : fall_pc;
            out_mispredict <= (cmp_taken != in_pred_taken);
            out_illegal    <= cmp_illegal;
         end else if (out_hs) begin
            out_valid <= 1'b0;
         end
         // Count saturates rather than wrapping so software sees a pinned maximum.
         if (out_hs && out_mispredict && (mispredict_cnt != {CNT_W{1'b1}}))
            mispredict_cnt <= mispredict_cnt + 1'b1;
      end
   end

`ifdef BRU_BHT_EN
   bht_ctr_t         bht [BHT_DEPTH];
   logic [IDX_W-1:0] out_idx;
   logic [IDX_W-1:0] lookup_idx;
   logic             unused_pred_pc;

   assign lookup_idx     = pred_pc[IDX_W+1:2];
   assign pred_taken     = bht[lookup_idx][1];
   assign unused_pred_pc = ^{pred_pc[XLEN-1:IDX_W+2], pred_pc[1:0]};

   // Table is written at the edge, so a same-cycle lookup sees the old counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < BHT_DEPTH; i++) bht[i] <= BHT_WEAK_NT;
         out_idx <= '0;
      end else begin
         if (in_hs) out_idx <= in_pc[IDX_W+1:2];
         if (out_hs && !out_illegal) begin
            if (out_taken && (bht[out_idx] != 2'b11))
               bht[out_idx] <= bht[out_idx] + 2'b01;
            else if (!out_taken && (bht[out_idx] != 2'b00))
               bht[out_idx] <= bht[out_idx] - 2'b01;
         end
      end
   end
`else
   logic unused_pred_pc;

   assign pred_taken     = 1'b0;
   assign unused_pred_pc = ^pred_pc;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed corner cases, then random traffic
// checked against a queue-based reference model.
module tb_branch_resolve_unit;

   localparam int XLEN      = 32;
   localparam int BHT_DEPTH = 64;
   localparam int CNT_W     = 4;
   localparam int CNT_MAX   = (1 << CNT_W) - 1;

   typedef struct {
      logic        taken;
      logic [31:0] next_pc;
      logic        mis;
      logic        ill;
      logic [31:0] pc;
   } res_t;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [XLEN-1:0]  in_pc, in_imm, in_rdata1, in_rdata2;
   logic [2:0]       in_func3;
   logic             in_pred_taken;
   logic             out_valid;
   logic             out_ready;
   logic             out_taken;
   logic [XLEN-1:0]  out_next_pc;
   logic             out_mispredict;
   logic             out_illegal;
   logic [CNT_W-1:0] mispredict_cnt;
   logic [XLEN-1:0]  pred_pc;
   logic             pred_taken;

   int   errors = 0;
   int   checks = 0;
   res_t q[$];
   int   m_cnt;
   int   m_bht[BHT_DEPTH];

   always #5 clk = ~clk;

   branch_resolve_unit #(.XLEN(XLEN), .BHT_DEPTH(BHT_DEPTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_pc(in_pc), .in_imm(in_imm), .in_rdata1(in_rdata1), .in_rdata2(in_rdata2),
      .in_func3(in_func3), .in_pred_taken(in_pred_taken),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_taken(out_taken), .out_next_pc(out_next_pc),
      .out_mispredict(out_mispredict), .out_illegal(out_illegal),
      .mispredict_cnt(mispredict_cnt),
      .pred_pc(pred_pc), .pred_taken(pred_taken)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference: branch semantics straight from the ISA rules.
   function automatic res_t model(input logic [31:0] pc, imm, r1, r2,
                                  input logic [2:0] f3, input logic pt);
      res_t r;
      r.ill = (f3 == 3'd2) || (f3 == 3'd3);
      case (f3)
         3'd0:    r.taken = (r1 == r2);
         3'd1:    r.taken = (r1 != r2);
         3'd4:    r.taken = (int'(r1) <  int'(r2));
         3'd5:    r.taken = (int'(r1) >= int'(r2));
         3'd6:    r.taken = (r1 <  r2);
         3'd7:    r.taken = (r1 >= r2);
         default: r.taken = 1'b0;
      endcase
      r.next_pc = r.taken ? pc + imm : pc + 32'd4;
      r.mis     = (r.taken != pt);
      r.pc      = pc;
      return r;
   endfunction

   function automatic logic model_pred(input logic [31:0] ppc);
`ifdef BRU_BHT_EN
      return m_bht[(ppc >> 2) % BHT_DEPTH] >= 2;
`else
      return 1'b0;
`endif
   endfunction

   task automatic model_reset();
      q.delete();
      m_cnt = 0;
      for (int i = 0; i < BHT_DEPTH; i++) m_bht[i] = 1;
   endtask

   task automatic step(input logic iv, input logic [31:0] pc, imm, r1, r2,
                       input logic [2:0] f3, input logic pt, input logic ordy,
                       input logic [31:0] ppc);
      logic exp_rdy, ohs, ihs;
      res_t r;
      int   idx;
      @(negedge clk);
      in_valid = iv; in_pc = pc; in_imm = imm; in_rdata1 = r1; in_rdata2 = r2;
      in_func3 = f3; in_pred_taken = pt; out_ready = ordy; pred_pc = ppc;
      #1;
      chk("out_valid", out_valid, q.size() != 0);
      if (q.size() != 0) begin
         chk("out_taken", out_taken, q[0].taken);
         chk("out_next_pc", out_next_pc, q[0].next_pc);
         chk("out_mispredict", out_mispredict, q[0].mis);
         chk("out_illegal", out_illegal, q[0].ill);
      end
      exp_rdy = (q.size() == 0) || ordy;
      chk("in_ready", in_ready, exp_rdy);
      chk("mispredict_cnt", mispredict_cnt, m_cnt);
      chk("pred_taken", pred_taken, model_pred(ppc));
      ohs = (q.size() != 0) && ordy;
      ihs = iv && exp_rdy;
      @(posedge clk);
      if (ohs) begin
         r = q.pop_front();
         if (r.mis && m_cnt < CNT_MAX) m_cnt++;
         if (!r.ill) begin
            idx = (r.pc >> 2) % BHT_DEPTH;
            if (r.taken && m_bht[idx] < 3) m_bht[idx]++;
            else if (!r.taken && m_bht[idx] > 0) m_bht[idx]--;
         end
      end
      if (ihs) q.push_back(model(pc, imm, r1, r2, f3, pt));
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk);
      model_reset();
      #1;
      rst = 1'b0; in_valid = 1'b0;
   endtask

   initial begin
      logic [31:0] r1, r2, pc, imm, ppc;
      logic [2:0]  f3;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_pc = '0; in_imm = '0;
      in_rdata1 = '0; in_rdata2 = '0; in_func3 = '0; in_pred_taken = 1'b0; pred_pc = '0;
      repeat (2) @(posedge clk);
      model_reset();
      #1 rst = 1'b0;

      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_taken", out_taken, 0);
      chk("rst_next_pc", out_next_pc, 0);
      chk("rst_mispredict", out_mispredict, 0);
      chk("rst_illegal", out_illegal, 0);
      chk("rst_cnt", mispredict_cnt, 0);
      chk("rst_pred_taken", pred_taken, 0);

      // Signed vs unsigned compare on the same operands.
      step(1, 32'h0, 32'h10, 32'hFFFF_FFFF, 32'h1, 3'b100, 1, 1, 32'h0);
      #1 chk("blt_taken", out_taken, 1);
      step(1, 32'h0, 32'h10, 32'hFFFF_FFFF, 32'h1, 3'b110, 0, 1, 32'h0);
      #1 chk("bltu_taken", out_taken, 0);
      step(1, 32'h100, 32'hFFFF_FFF0, 32'h5, 32'h5, 3'b000, 0, 1, 32'h0);
      #1 chk("beq_next_pc", out_next_pc, 32'h0F0);
      chk("beq_mispredict", out_mispredict, 1);
      step(1, 32'hFFFF_FFFC, 32'h8, 32'h1, 32'h2, 3'b000, 0, 1, 32'h0);
      #1 chk("cnt_after_mispredict", mispredict_cnt, 1);
      chk("wrap_next_pc", out_next_pc, 32'h0);

      // Stall with a second input pending.
      for (int i = 0; i < 3; i++) begin
         step(1, 32'h200, 32'h20, 32'h5, 32'h3, 3'b111, 1, 0, 32'h0);
         #1 chk("stall_in_ready", in_ready, 0);
         chk("stall_next_pc", out_next_pc, 32'h0);
      end
      step(1, 32'h200, 32'h20, 32'h5, 32'h3, 3'b111, 1, 1, 32'h0);
      #1 chk("after_stall_next_pc", out_next_pc, 32'h220);
      chk("after_stall_valid", out_valid, 1);
      step(0, 32'h0, 32'h0, 32'h0, 32'h0, 3'b000, 0, 1, 32'h0);

      // Three taken BNE at 0x40 train the predictor entry.
      step(1, 32'h40, 32'h40, 32'h1, 32'h2, 3'b001, 0, 1, 32'h40);
      #1 chk("bht_same_cycle", pred_taken, 0);
      step(1, 32'h40, 32'h40, 32'h1, 32'h2, 3'b001, 0, 1, 32'h40);
`ifdef BRU_BHT_EN
      #1 chk("bht_after_1", pred_taken, 1);
`else
      #1 chk("bht_after_1", pred_taken, 0);
`endif
      step(1, 32'h40, 32'h40, 32'h1, 32'h2, 3'b001, 0, 1, 32'h40);
      step(0, 32'h0, 32'h0, 32'h0, 32'h0, 3'b000, 0, 1, 32'h40);

      // Reserved func3 at the same PC must leave the entry untouched.
      step(1, 32'h40, 32'h40, 32'h1, 32'h1, 3'b010, 1, 1, 32'h40);
      #1 chk("illegal_flag", out_illegal, 1);
      chk("illegal_taken", out_taken, 0);
      step(1, 32'h40, 32'h40, 32'h1, 32'h1, 3'b011, 1, 1, 32'h40);
      step(0, 32'h0, 32'h0, 32'h0, 32'h0, 3'b000, 0, 1, 32'h40);
`ifdef BRU_BHT_EN
      #1 chk("bht_after_illegal", pred_taken, 1);
`else
      #1 chk("bht_after_illegal", pred_taken, 0);
`endif

      // Reset while a mispredicted result is stalled.
      step(1, 32'h300, 32'h8, 32'h1, 32'h2, 3'b000, 1, 1, 32'h0);
      step(0, 32'h0, 32'h0, 32'h0, 32'h0, 3'b000, 0, 0, 32'h0);
      do_reset();
      chk("midstall_rst_valid", out_valid, 0);
      chk("midstall_rst_cnt", mispredict_cnt, 0);

      for (int n = 0; n < 500; n++) begin
         r1 = $urandom;
         case ($urandom_range(0, 2))
            0:       r2 = r1;
            1:       r2 = $urandom;
            default: r2 = r1 ^ 32'h8000_0000;
         endcase
         if ($urandom_range(0, 3) == 0) pc = 32'hFFFF_FFF0 | ($urandom_range(0, 3) << 2);
         else                           pc = $urandom_range(0, 255) << 2;
         imm = ($urandom_range(0, 1) == 0) ? ($urandom & 32'hFFFF_FFFE) : ($urandom_range(0, 64) << 1);
         f3  = 3'($urandom_range(0, 7));
         ppc = $urandom_range(0, 255) << 2;
         step($urandom_range(0, 9) < 7, pc, imm, r1, r2, f3, $urandom_range(0, 1) == 1,
              $urandom_range(0, 9) < 7, ppc);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
